mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle multiply/divide unit owning the architectural HI/LO registers; the execute-stage consumer of the decoder's `mult`, `div`, `isUnsigned` and HI/LO-move controls. It accepts MULT/MULTU/DIV/DIVU operands from execute, iterates a 32-step shift-add / restoring-subtract datapath, and signals `busy` so the pipeline stalls MFHI/MFLO and further mult/div until the result is committed. MTHI/MTLO writes land here directly.

## Interface
- `WIDTH`, 32, operand width; HI and LO each `WIDTH` bits.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  issue pulse; qualified by exactly one of `mult`/`div`.
- `mult`  in  1  MULT/MULTU selected.
- `div`  in  1  DIV/DIVU selected.
- `isUnsigned`  in  1  unsigned variant (MULTU/DIVU).
- `a`  in  WIDTH  rs value (multiplicand / dividend).
- `b`  in  WIDTH  rt value (multiplier / divisor).
- `hiWrite`  in  1  MTHI.
- `loWrite`  in  1  MTLO.
- `wData`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight; pipeline stalls HI/LO readers and new `start`.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO are committed.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- Reset: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0.
- States: IDLE, CALC, FIX. `busy` = (state != IDLE).
- IDLE + `start`: latch operation, signedness; take magnitudes of `a`,`b` when signed; record result signs; counter=0; go CALC.
- CALC: one iteration per cycle; counter 0..31; at counter 31 go FIX.
  - Multiply: 64-bit shift-add of magnitudes.
  - Divide: restoring radix-2; 33-bit partial remainder.
- FIX: apply sign correction; write HI/LO; go IDLE; `done`=1 next cycle.
- Signed multiply: 64-bit product negated iff sign(a) XOR sign(b). HI=product[63:32], LO=product[31:0].
- Signed divide: LO=quotient negated iff sign(a) XOR sign(b); HI=remainder carrying sign(a). 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero (either signedness): full latency; LO=0xFFFFFFFF, HI=`a` unmodified.
- `start` while `busy`: ignored (bench flags as pipeline error).
- `start` with both or neither of `mult`/`div`: ignored.
- `hiWrite`/`loWrite` in IDLE: register written at that edge.
- `hiWrite`/`loWrite` while `busy`: in-flight operation cancelled, write applied, state -> IDLE, no `done`.
- `hiWrite`/`loWrite` with `start` same cycle: write wins, `start` dropped.
- `reset` mid-operation: returns to reset values at that edge; no `done`.

## Timing
- `start` sampled at edge E0; CALC iterations at E1..E32; FIX commits HI/LO at E33.
- `busy` high from after E0 through E33 (33 cycles); `done` high in the cycle after E33.
- Back-to-back: next `start` accepted at E33+1 (`busy` low that cycle).
- `hi`/`lo` are registered; values visible the cycle after the committing edge. No combinational path from inputs to outputs.

## Configuration
- `MDU_FAST_MULT_EN` defined: MULT/MULTU use a single-cycle 32x32 product; HI/LO committed at E0, `busy` never asserted, `done` high the cycle after E0. Divide unchanged.
- Undefined: multiply uses the iterative CALC/FIX path with divide timing (33 busy cycles).

## Structure
- `MduStateEnum` (IDLE, CALC, FIX) in the shared `Enum` include; `MDU_ITERATIONS` (=32) and divide-by-zero LO constant in the `Parameter` package.
- One sub-module: `mdu_core`, the per-iteration combinational step (shift-add or subtract-compare) on accumulator/remainder; FSM, sign handling and HI/LO registers stay in `mul_div_unit`.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 busy cycles HI=0xFFFFFFFE, LO=0x00000001, `done` one cycle.
- MULT 0xFFFFFFFE (-2) x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; with `MDU_FAST_MULT_EN`, same values, `busy` never high.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5.
- MTLO 0x1234 at cycle 10 of a DIV -> LO=0x1234, HI unchanged, `busy` low next cycle, no `done`.
- `reset` at cycle 5 of MULTU -> HI=LO=0, `busy`=0; `start` during `busy` leaves result of first op intact.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit_pkg
//  Description : Shared state encoding and constants for the multiply/divide
//                unit (iteration count, divide-by-zero LO fill value).
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_div_unit_pkg;

    // Number of datapath iterations for one multiply or divide
    localparam int MDU_ITERATIONS = 32;

    // LO is filled with this bit on divide by zero (LO = all ones)
    localparam logic MDU_DIV0_LO_FILL = 1'b1;

    // Control states of the multi-cycle engine
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } MduStateEnum;

endpackage : mul_div_unit_pkg
`default_nettype wire

// File: rtl/mdu_core.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_core
//  Description : One combinational iteration of the multiply/divide datapath.
//                Multiply: shift-add step on the {upper,lower} product pair,
//                lower holding the not-yet-consumed multiplier bits.
//                Divide: restoring step, upper = partial remainder,
//                lower = dividend bits shifting out / quotient bits in.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_core
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_upper,
    input  logic [WIDTH-1:0] i_lower,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_next_upper,
    output logic [WIDTH-1:0] o_next_lower
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // Single shift-add or subtract-compare step selected by operation type
    always_comb begin
        w_sum        = {1'b0, i_upper} + {1'b0, i_operand};
        w_shifted    = {i_upper, i_lower[WIDTH-1]};
        w_diff       = w_shifted - {1'b0, i_operand};
        o_next_upper = i_upper;
        o_next_lower = i_lower;
        if (i_is_div) begin
            // Remainder stays below the divisor, so it always fits WIDTH bits
            if (!w_diff[WIDTH]) begin
                o_next_upper = w_diff[WIDTH-1:0];
                o_next_lower = {i_lower[WIDTH-2:0], 1'b1};
            end else begin
                o_next_upper = w_shifted[WIDTH-1:0];
                o_next_lower = {i_lower[WIDTH-2:0], 1'b0};
            end
        end else if (i_lower[0]) begin
            o_next_upper = w_sum[WIDTH:1];
            o_next_lower = {w_sum[0], i_lower[WIDTH-1:1]};
        end else begin
            o_next_upper = {1'b0, i_upper[WIDTH-1:1]};
            o_next_lower = {i_upper[0], i_lower[WIDTH-1:1]};
        end
    end

endmodule : mdu_core
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO.
//                IDLE -> CALC (32 iterations) -> FIX (sign fix, commit).
//                MTHI/MTLO writes cancel any operation in flight.
//                Build option MDU_FAST_MULT_EN: multiplies complete in a
//                single cycle from IDLE; divide timing is unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mult,
    input  logic             div,
    input  logic             isUnsigned,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] wData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(MDU_ITERATIONS);

    MduStateEnum        r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div0;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_upper;
    logic [WIDTH-1:0]   r_lower;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_issue;
    logic               w_fast_hit;
    logic [2*WIDTH-1:0] w_fast_prod;
    logic [2*WIDTH-1:0] w_prod_fixed;
    logic [WIDTH-1:0]   w_next_upper;
    logic [WIDTH-1:0]   w_next_lower;

    // Operand signs and magnitudes; unsigned variants are treated as positive
    always_comb begin
        w_sign_a     = a[WIDTH-1] & ~isUnsigned;
        w_sign_b     = b[WIDTH-1] & ~isUnsigned;
        w_mag_a      = w_sign_a ? -a : a;
        w_mag_b      = w_sign_b ? -b : b;
        // A HI/LO move in the same cycle takes precedence over a new issue
        w_issue      = start & (mult ^ div) & (r_state == IDLE) & ~hiWrite & ~loWrite;
        w_prod_fixed = r_neg_res ? -{r_upper, r_lower} : {r_upper, r_lower};
    end

`ifdef MDU_FAST_MULT_EN
    // Full-width product of sign-extended operands; low 2*WIDTH bits are exact
    always_comb begin
        w_fast_hit  = mult;
        w_fast_prod = {{WIDTH{w_sign_a}}, a} * {{WIDTH{w_sign_b}}, b};
    end
`else
    // Multiplies always take the iterative path
    always_comb begin
        w_fast_hit  = 1'b0;
        w_fast_prod = '0;
    end
`endif

    mdu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_is_div     (r_is_div),
        .i_upper      (r_upper),
        .i_lower      (r_lower),
        .i_operand    (r_operand),
        .o_next_upper (w_next_upper),
        .o_next_lower (w_next_lower)
    );

    // Control FSM, iteration registers and architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_a_raw   <= '0;
            r_operand <= '0;
            r_upper   <= '0;
            r_lower   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (hiWrite || loWrite) begin
                if (hiWrite) r_hi <= wData;
                if (loWrite) r_lo <= wData;
                r_state <= IDLE;
                r_count <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_issue && w_fast_hit) begin
                            r_hi   <= w_fast_prod[2*WIDTH-1:WIDTH];
                            r_lo   <= w_fast_prod[WIDTH-1:0];
                            r_done <= 1'b1;
                        end else if (w_issue) begin
                            r_is_div  <= div;
                            r_neg_res <= w_sign_a ^ w_sign_b;
                            r_neg_rem <= w_sign_a;
                            r_div0    <= (b == '0);
                            r_a_raw   <= a;
                            // Divide iterates on the dividend, multiply on the multiplier
                            r_operand <= div ? w_mag_b : w_mag_a;
                            r_lower   <= div ? w_mag_a : w_mag_b;
                            r_upper   <= '0;
                            r_count   <= '0;
                            r_state   <= CALC;
                        end
                    end
                    CALC: begin
                        r_upper <= w_next_upper;
                        r_lower <= w_next_lower;
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == CNT_W'(MDU_ITERATIONS - 1)) r_state <= FIX;
                    end
                    FIX: begin
                        if (r_is_div && r_div0) begin
                            r_hi <= r_a_raw;
                            r_lo <= {WIDTH{MDU_DIV0_LO_FILL}};
                        end else if (r_is_div) begin
                            r_hi <= r_neg_rem ? -r_upper : r_upper;
                            r_lo <= r_neg_res ? -r_lower : r_lower;
                        end else begin
                            r_hi <= w_prod_fixed[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fixed[WIDTH-1:0];
                        end
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule : mul_div_unit
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Scoreboard bench for mul_div_unit. Expected {HI,LO} pairs
//                are computed with plain integer arithmetic and queued at
//                issue; a monitor pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, mult, div, isUnsigned, hiWrite, loWrite;
    logic [W-1:0] a, b, wData;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int           checks = 0;
    int           errors = 0;
    logic [63:0]  exp_q[$];
    logic [31:0]  m_hi = '0;
    logic [31:0]  m_lo = '0;
    bit           prev_done = 1'b0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mult       (mult),
        .div        (div),
        .isUnsigned (isUnsigned),
        .a          (a),
        .b          (b),
        .hiWrite    (hiWrite),
        .loWrite    (loWrite),
        .wData      (wData),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    // Reference: returns {HI, LO} from integer arithmetic
    function automatic logic [63:0] ref_model(input bit is_div, input bit uns,
                                              input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!is_div) begin
            if (uns) p = {32'h0, x} * {32'h0, y};
            else     p = sx * sy;
            return p;
        end
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (uns) return {x % y, x / y};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            chk("done_single_cycle", {63'h0, prev_done}, 64'h0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done=1 expected no done (hi=%h lo=%h)", hi, lo);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("result_hi", {32'h0, hi}, {32'h0, e[63:32]});
                chk("result_lo", {32'h0, lo}, {32'h0, e[31:0]});
            end
        end
        prev_done = done;
    end

    task automatic drive_op(input bit is_div, input bit uns, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; mult = !is_div; div = is_div; isUnsigned = uns; a = x; b = y;
        @(negedge clk);
        start = 1'b0; mult = 1'b0; div = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input bit is_div, input bit uns,
                          input logic [31:0] x, input logic [31:0] y);
        logic [63:0] e;
        int          n;
        int          exp_busy;
        e = ref_model(is_div, uns, x, y);
        exp_q.push_back(e);
        m_hi = e[63:32];
        m_lo = e[31:0];
        exp_busy = 33;
`ifdef MDU_FAST_MULT_EN
        if (!is_div) exp_busy = 0;
`endif
        drive_op(is_div, uns, x, y);
        wait_idle(n);
        chk({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; mult = 1'b0; div = 1'b0; isUnsigned = 1'b0;
        a = '0; b = '0; hiWrite = 1'b0; loWrite = 1'b0; wData = '0;
        repeat (3) @(negedge clk);
        chk("reset_hi",   {32'h0, hi}, 64'h0);
        chk("reset_lo",   {32'h0, lo}, 64'h0);
        chk("reset_busy", {63'h0, busy}, 64'h0);
        chk("reset_done", {63'h0, done}, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // Directed corner cases
        run_op("multu_max",   1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg",    1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003);
        run_op("div_neg",     1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op("divu_pos",    1'b1, 1'b1, 32'h0000_0007, 32'h0000_0002);
        run_op("div_ovf",     1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_zero",   1'b1, 1'b1, 32'h0000_0005, 32'h0000_0000);
        run_op("div_zero",    1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0000);

        // MTHI while idle
        hiWrite = 1'b1; wData = 32'hCAFE_0001;
        @(negedge clk);
        hiWrite = 1'b0;
        m_hi = 32'hCAFE_0001;
        chk("mthi_idle_hi", {32'h0, hi}, {32'h0, m_hi});
        chk("mthi_idle_lo", {32'h0, lo}, {32'h0, m_lo});

        // MTLO cancels a divide in flight: no done, HI untouched
        drive_op(1'b1, 1'b0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        loWrite = 1'b1; wData = 32'h0000_1234;
        @(negedge clk);
        loWrite = 1'b0;
        m_lo = 32'h0000_1234;
        chk("mtlo_cancel_lo",   {32'h0, lo}, {32'h0, m_lo});
        chk("mtlo_cancel_hi",   {32'h0, hi}, {32'h0, m_hi});
        chk("mtlo_cancel_busy", {63'h0, busy}, 64'h0);
        repeat (40) @(negedge clk);

        // Write and start in the same cycle: write wins, start dropped
        hiWrite = 1'b1; wData = 32'h5A5A_0F0F;
        start = 1'b1; mult = 1'b1; div = 1'b0; isUnsigned = 1'b1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        hiWrite = 1'b0; start = 1'b0; mult = 1'b0;
        m_hi = 32'h5A5A_0F0F;
        chk("write_vs_start_busy", {63'h0, busy}, 64'h0);
        chk("write_vs_start_hi",   {32'h0, hi}, {32'h0, m_hi});
        chk("write_vs_start_lo",   {32'h0, lo}, {32'h0, m_lo});
        repeat (40) @(negedge clk);

        // Both selects asserted: ignored
        start = 1'b1; mult = 1'b1; div = 1'b1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; mult = 1'b0; div = 1'b0;
        chk("both_sel_busy", {63'h0, busy}, 64'h0);
        chk("both_sel_hi",   {32'h0, hi}, {32'h0, m_hi});
        repeat (5) @(negedge clk);

        // Reset mid-operation clears HI/LO and aborts without done
`ifdef MDU_FAST_MULT_EN
        drive_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0003);
`else
        drive_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`endif
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_hi",   {32'h0, hi}, 64'h0);
        chk("midreset_lo",   {32'h0, lo}, 64'h0);
        chk("midreset_busy", {63'h0, busy}, 64'h0);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (40) @(negedge clk);

        // Start while busy is ignored; first result must survive
        exp_q.push_back(ref_model(1'b1, 1'b0, 32'd1000, 32'hFFFF_FFFD));
        drive_op(1'b1, 1'b0, 32'd1000, 32'hFFFF_FFFD);
        repeat (5) @(negedge clk);
        drive_op(1'b0, 1'b1, 32'd5, 32'd6);
        wait_idle(n);
        chk("start_while_busy_latency", 64'(n), 64'd27);
        repeat (40) @(negedge clk);

        // Randomized operations with biased corner operands
        for (int i = 0; i < 40; i++) begin
            logic [31:0] x, y;
            int          sel;
            bit          is_div, uns;
            is_div = 1'($urandom_range(0, 1));
            uns    = 1'($urandom_range(0, 1));
            x      = $urandom;
            y      = $urandom;
            sel    = $urandom_range(0, 7);
            if (sel == 0) y = 32'h0;
            if (sel == 1) y = 32'hFFFF_FFFF;
            if (sel == 2) y = $urandom_range(1, 15);
            if (sel == 3) x = 32'h8000_0000;
            run_op("random", is_div, uns, x, y);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mul_div_unit
`default_nettype wire
